fft_peak_detector: RTL and testbench
====================================

Name: fft_peak_detector

Overview:
- Consumer (sink) for the streaming output of the FFT core; the FFT input side is fed by the existing FFT control block.
- Accepts one Avalon-ST frame of N_PTS complex bins and forms an L1 magnitude, |re|+|im|, for each bin.
- Tracks the strongest bin in the positive-frequency half and presents bin index, magnitude and block exponent to the note-detection logic through a valid/ready result port.

Parameters:
N_PTS, 8192, FFT frame length in beats; power of two
DATA_W, 16, width of source_real / source_imag (signed)
BIN_W, 13, bin index width; equals log2(N_PTS)
MIN_BIN, 1, lowest bin eligible for peak search (excludes DC)
MAG_THRESH, 0, magnitude must be strictly greater than this to be eligible

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
source_valid  in  1  FFT output beat valid
source_ready  out  1  block accepts beat
source_sop  in  1  first beat of frame
source_eop  in  1  last beat of frame
source_error  in  2  FFT error code; nonzero = bad beat
source_real  in  DATA_W  bin real part, signed
source_imag  in  DATA_W  bin imag part, signed
source_exp  in  6  block-floating exponent, signed
peak_bin  out  BIN_W  index of strongest eligible bin
peak_mag  out  DATA_W+1  magnitude of that bin
peak_exp  out  6  exponent latched at sop
peak_found  out  1  at least one eligible bin exceeded MAG_THRESH
frame_err  out  1  frame was malformed or flagged
result_valid  out  1  result registers hold an unread result
result_ready  in  1  consumer takes result

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. Every register clears on assertion; release is synchronous to clk.
- Reset values: all outputs 0 except source_ready, which is 1 once reset is released.
- Beat acceptance: a beat is accepted when source_valid && source_ready.
- source_ready = !result_valid || result_ready. Combinational, so the stream stalls only while an unread result is pending.
- Magnitude:
  - mag = |re| + |im|, computed combinationally at DATA_W+1 bits, unsigned.
  - The absolute value of -2^(DATA_W-1) is 2^(DATA_W-1); no saturation is needed because it fits in DATA_W+1 bits.
- State machine S_IDLE:
  - Accepted beats without sop are dropped silently.
  - An accepted sop beat: bin_idx<=1, best_mag<=0, best_bin<=0, found<=0, err<=(source_error!=0), exp_lat<=source_exp, go to S_FRAME.
  - Bin 0 (the sop beat) is still evaluated if MIN_BIN=0.
- State machine S_FRAME:
  - Each accepted beat is evaluated at index bin_idx, then bin_idx increments.
  - A nonzero source_error on any beat sets err.
- Eligibility:
  - A bin is eligible when MIN_BIN <= idx <= N_PTS/2-1 and mag > MAG_THRESH.
  - It updates best_mag/best_bin only if mag > best_mag. Strict comparison, so on ties the lowest bin wins.
- Frame end: an accepted eop beat (including a sop+eop single beat) is evaluated first. Then, on the next edge:
  - result registers load the final best values, peak_found, and frame_err = err || (beat index != N_PTS-1);
  - result_valid<=1;
  - the state returns to S_IDLE.
- Result handshake:
  - result_valid stays asserted, with all result outputs stable, until it is sampled with result_ready=1. It then clears on the next edge unless a new result loads on the same edge; in that case it stays 1 with the new data.
- sop while in S_FRAME:
  - The current frame is aborted with no result.
  - The frame restarts as in S_IDLE from this beat.
  - The sticky counter status bit is not required.
- bin_idx overflow: if N_PTS beats arrive without eop, bin_idx wraps to 0. Further beats are not eligible, the frame is marked err, and the block waits for eop or sop.
- Reset mid-frame: the partial frame is discarded and the block returns to S_IDLE.
- Latency: one cycle from the accepted eop beat to result_valid.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_N_PTS=8192 and FFT_BIN_W=13;
  - FFT_EXP_W=6;
  - FFT state enum {S_IDLE,S_FRAME}.
- One natural sub-module, fft_mag_l1: a combinational abs-sum of re/im that can later be reused by the spectrum display path.

Test Plan:
- Clean frame, N_PTS=16 for simulation: all bins re=im=0 except bin 5 (re=-300, im=200), exp=-3 at sop -> result_valid one cycle after eop; peak_bin=5, peak_mag=500, peak_exp=-3, peak_found=1, frame_err=0.
- Tie and mirror: bins 3 and 6 both mag=100, bin 12 (negative half) mag=900 -> peak_bin=3, peak_mag=100. The DC bin with mag=1000 is ignored because MIN_BIN=1.
- Back-pressure: result_ready held low across a second frame -> source_ready drops the cycle after the first result loads. The second frame stalls with no beat lost; after result_ready=1 for one cycle, the first result is consumed and the second completes correctly.
- Short frame: eop at beat 9 of 16 -> result with frame_err=1 and the peak taken from beats 1..7.
- Error and abort: source_error=2'b01 on beat 4 -> frame_err=1. A separate frame receives sop at beat 6 -> no result for the aborted frame, and the next complete 16-beat frame reports correctly.
- Reset and threshold: with MAG_THRESH=50 and all mags <=50 -> peak_found=0, peak_bin=0, peak_mag=0. Asserting reset_n low mid-frame -> all outputs 0 immediately, and the next clean frame gives a correct result.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT output-side blocks.
package fft_pkg;

    localparam int FFT_N_PTS = 8192;
    localparam int FFT_BIN_W = 13;
    localparam int FFT_EXP_W = 6;

    typedef enum logic {
        S_IDLE,
        S_FRAME
    } fft_state_e;

endpackage

// File: rtl/fft_mag_l1.sv
// Combinational L1 magnitude |re|+|im| of one complex bin, full precision.
module fft_mag_l1 #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] re,
    input  logic signed [DATA_W-1:0] im,
    output logic        [DATA_W:0]   mag
);

    logic [DATA_W:0] re_ext;
    logic [DATA_W:0] im_ext;
    logic [DATA_W:0] re_abs;
    logic [DATA_W:0] im_abs;

    // One extra bit lets the most negative input negate without saturating.
    always_comb begin
        re_ext = {re[DATA_W-1], re};
        im_ext = {im[DATA_W-1], im};
        re_abs = re[DATA_W-1] ? (~re_ext + 1'b1) : re_ext;
        im_abs = im[DATA_W-1] ? (~im_ext + 1'b1) : im_ext;
        mag    = re_abs + im_abs;
    end

endmodule

// File: rtl/fft_peak_detector.sv
// Streaming FFT sink: finds the strongest positive-frequency bin of each frame
// and offers bin, magnitude and block exponent on a valid/ready result port.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int N_PTS      = FFT_N_PTS,
    parameter int DATA_W     = 16,
    parameter int BIN_W      = FFT_BIN_W,
    parameter int MIN_BIN    = 1,
    parameter int MAG_THRESH = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     source_valid,
    output logic                     source_ready,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic [1:0]               source_error,
    input  logic signed [DATA_W-1:0] source_real,
    input  logic signed [DATA_W-1:0] source_imag,
    input  logic [FFT_EXP_W-1:0]     source_exp,
    output logic [BIN_W-1:0]         peak_bin,
    output logic [DATA_W:0]          peak_mag,
    output logic [FFT_EXP_W-1:0]     peak_exp,
    output logic                     peak_found,
    output logic                     frame_err,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_PTS - 1);
    localparam logic [BIN_W-1:0] HALF_IDX = BIN_W'(N_PTS / 2 - 1);
    localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);
    localparam logic [DATA_W:0]  THRESH   = (DATA_W + 1)'(MAG_THRESH);

    fft_state_e           state;
    fft_state_e           state_nxt;
    logic [BIN_W-1:0]     bin_idx;
    logic [BIN_W-1:0]     bin_idx_nxt;
    logic [BIN_W-1:0]     cur_idx;
    logic [DATA_W:0]      mag;
    logic [DATA_W:0]      best_mag;
    logic [DATA_W:0]      best_mag_nxt;
    logic [DATA_W:0]      base_mag;
    logic [BIN_W-1:0]     best_bin;
    logic [BIN_W-1:0]     best_bin_nxt;
    logic [BIN_W-1:0]     base_bin;
    logic                 found;
    logic                 found_nxt;
    logic                 base_found;
    logic                 err;
    logic                 err_nxt;
    logic                 base_err;
    logic                 ovf;
    logic                 ovf_nxt;
    logic                 base_ovf;
    logic                 wrap;
    logic [FFT_EXP_W-1:0] exp_lat;
    logic [FFT_EXP_W-1:0] exp_nxt;
    logic                 accept;
    logic                 start;
    logic                 eligible;
    logic                 load_result;

    fft_mag_l1 #(
        .DATA_W(DATA_W)
    ) u_mag (
        .re (source_real),
        .im (source_imag),
        .mag(mag)
    );

    // Held low during reset; otherwise stalls only while an unread result waits.
    assign source_ready = reset_n && (!result_valid || result_ready);

    // A sop beat restarts the accumulators from scratch in either state, so the
    // beat is evaluated against fresh "base" values instead of the registers.
    always_comb begin
        accept       = source_valid && source_ready;
        start        = accept && source_sop;
        cur_idx      = start ? '0 : bin_idx;
        base_mag     = start ? '0 : best_mag;
        base_bin     = start ? '0 : best_bin;
        base_found   = start ? 1'b0 : found;
        base_err     = start ? 1'b0 : err;
        base_ovf     = start ? 1'b0 : ovf;
        exp_nxt      = start ? source_exp : exp_lat;
        wrap         = (cur_idx == LAST_IDX) && !source_eop;
        eligible     = !base_ovf && (cur_idx >= MIN_IDX) && (cur_idx <= HALF_IDX)
                       && (mag > THRESH);
        state_nxt    = state;
        bin_idx_nxt  = bin_idx;
        best_mag_nxt = best_mag;
        best_bin_nxt = best_bin;
        found_nxt    = found;
        err_nxt      = err;
        ovf_nxt      = ovf;
        load_result  = 1'b0;
        if (accept && (start || state == S_FRAME)) begin
            if (eligible && (mag > base_mag)) begin
                best_mag_nxt = mag;
                best_bin_nxt = cur_idx;
            end else begin
                best_mag_nxt = base_mag;
                best_bin_nxt = base_bin;
            end
            found_nxt   = base_found | eligible;
            err_nxt     = base_err | (source_error != 2'b00) | wrap;
            ovf_nxt     = base_ovf | wrap;
            bin_idx_nxt = cur_idx + 1'b1;
            if (source_eop) begin
                load_result = 1'b1;
                state_nxt   = S_IDLE;
            end else begin
                state_nxt = S_FRAME;
            end
        end
    end

    // Frame accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bin_idx  <= '0;
            best_mag <= '0;
            best_bin <= '0;
            found    <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            exp_lat  <= '0;
        end else begin
            state    <= state_nxt;
            bin_idx  <= bin_idx_nxt;
            best_mag <= best_mag_nxt;
            best_bin <= best_bin_nxt;
            found    <= found_nxt;
            err      <= err_nxt;
            ovf      <= ovf_nxt;
            exp_lat  <= exp_nxt;
        end
    end

    // Result port: a load can only happen when the previous result is gone or
    // being taken this cycle, so nothing unread is ever overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_bin     <= '0;
            peak_mag     <= '0;
            peak_exp     <= '0;
            peak_found   <= 1'b0;
            frame_err    <= 1'b0;
            result_valid <= 1'b0;
        end else if (load_result) begin
            peak_bin     <= best_bin_nxt;
            peak_mag     <= best_mag_nxt;
            peak_exp     <= exp_nxt;
            peak_found   <= found_nxt;
            frame_err    <= err_nxt || (cur_idx != LAST_IDX);
            result_valid <= 1'b1;
        end else if (result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Randomized self-checking bench for fft_peak_detector against a frame-level model.
module tb_fft_peak_detector;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int BW   = 4;
    localparam int MINB = 1;
    localparam int TH   = 50;

    typedef struct {
        bit         valid;
        bit         sop;
        bit         eop;
        logic [1:0] err;
        int         re;
        int         im;
        logic [5:0] ex;
    } beat_t;

    typedef struct packed {
        logic [BW-1:0] bin;
        logic [DW:0]   mag;
        logic [5:0]    ex;
        logic          found;
        logic          ferr;
    } res_t;

    logic                 clk;
    logic                 reset_n;
    logic                 source_valid;
    logic                 source_ready;
    logic                 source_sop;
    logic                 source_eop;
    logic [1:0]           source_error;
    logic signed [DW-1:0] source_real;
    logic signed [DW-1:0] source_imag;
    logic [5:0]           source_exp;
    logic [BW-1:0]        peak_bin;
    logic [DW:0]          peak_mag;
    logic [5:0]           peak_exp;
    logic                 peak_found;
    logic                 frame_err;
    logic                 result_valid;
    logic                 result_ready;

    beat_t stim[$];
    res_t  exp_q[$];
    res_t  got_q[$];
    int    fre[40];
    int    fim[40];
    int    tests;
    int    fails;

    fft_peak_detector #(
        .N_PTS(N), .DATA_W(DW), .BIN_W(BW), .MIN_BIN(MINB), .MAG_THRESH(TH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error), .source_real(source_real),
        .source_imag(source_imag), .source_exp(source_exp),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_exp(peak_exp),
        .peak_found(peak_found), .frame_err(frame_err),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records each result on the cycle it is handed over.
    always @(negedge clk) begin
        if (reset_n && result_valid && result_ready)
            got_q.push_back({peak_bin, peak_mag, peak_exp, peak_found, frame_err});
    end

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference: position in frame is the bin; peak over eligible positive bins.
    function automatic res_t eval_frame(input beat_t f[$]);
        res_t r;
        int   best = 0;
        int   bbin = 0;
        bit   fnd  = 0;
        bit   e    = 0;
        for (int i = 0; i < f.size(); i++) begin
            int m = iabs(f[i].re) + iabs(f[i].im);
            if (f[i].err != 2'b00) e = 1;
            if (i >= MINB && i <= N / 2 - 1 && m > TH) begin
                fnd = 1;
                if (m > best) begin
                    best = m;
                    bbin = i;
                end
            end
        end
        if (f.size() != N) e = 1;
        r.bin   = BW'(bbin);
        r.mag   = (DW + 1)'(best);
        r.ex    = f[0].ex;
        r.found = fnd;
        r.ferr  = e;
        return r;
    endfunction

    task automatic model_stream(input beat_t s[$]);
        beat_t fr[$];
        bit    inf = 0;
        for (int i = 0; i < s.size(); i++) begin
            if (!s[i].valid) continue;
            if (s[i].sop) begin
                fr.delete();
                fr.push_back(s[i]);
                inf = 1;
            end else if (inf) begin
                fr.push_back(s[i]);
            end else begin
                continue;
            end
            if (s[i].eop) begin
                exp_q.push_back(eval_frame(fr));
                inf = 0;
            end
        end
    endtask

    task automatic add_beat(input int re, input int im, input bit sop, input bit eop,
                            input logic [1:0] e, input logic [5:0] ex, input bit v);
        beat_t b;
        b.valid = v; b.sop = sop; b.eop = eop; b.err = e;
        b.re = re; b.im = im; b.ex = ex;
        stim.push_back(b);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 40; i++) begin
            fre[i] = 0;
            fim[i] = 0;
        end
    endtask

    task automatic rand_fill();
        for (int i = 0; i < 40; i++) begin
            fre[i] = int'($urandom_range(0, 600)) - 300;
            fim[i] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    // Frame from fre/fim with random idle gaps; exp is meaningful only on sop.
    task automatic add_frame(input int len, input int err_at, input logic [1:0] ecode,
                             input logic [5:0] ex);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 4) == 0)
                add_beat(int'($urandom_range(0, 99)), 0, 1'($urandom), 1'($urandom),
                         2'b11, 6'($urandom), 1'b0);
            add_beat(fre[i], fim[i], i == 0, i == len - 1,
                     (i == err_at) ? ecode : 2'b00, (i == 0) ? ex : 6'($urandom), 1'b1);
        end
    endtask

    task automatic drive_beat(input beat_t b);
        int w = 0;
        @(negedge clk);
        source_valid = b.valid;
        source_sop   = b.sop;
        source_eop   = b.eop;
        source_error = b.err;
        source_real  = DW'(b.re);
        source_imag  = DW'(b.im);
        source_exp   = b.ex;
        #1;
        if (b.valid) begin
            while (!source_ready && w < 1000) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= 1000) begin
                tests++;
                fails++;
                $display("[TB] FAIL beat_accept_timeout: source_ready stuck at %0b, required 1", source_ready);
            end
        end
        @(posedge clk);
    endtask

    // Drives every queued beat, then idles the bus on the following negedge.
    task automatic send_stream(input bit do_model);
        for (int i = 0; i < stim.size(); i++) drive_beat(stim[i]);
        @(negedge clk);
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        if (do_model) model_stream(stim);
        stim.delete();
    endtask

    task automatic wait_results();
        int c = 0;
        while (got_q.size() < exp_q.size() && c < 300) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 result_ready = v;
    endtask

    task automatic applyStimulus_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({peak_bin, peak_mag, peak_exp, peak_found, frame_err, result_valid, source_ready} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got bin=%0d mag=%0d exp=%0d found=%0b err=%0b rv=%0b rdy=%0b, required all 0",
                     peak_bin, peak_mag, peak_exp, peak_found, frame_err, result_valid, source_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests++;
        if (source_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_after_reset: got %0b, required 1", source_ready);
        end
    endtask

    task automatic test_clean();
        clear_frame();
        fre[5] = -300;
        fim[5] = 200;
        add_frame(N, -1, 2'b00, 6'h3D);
        send_stream(1);
        #1;
        tests++;
        if (result_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clean_latency: result_valid=%0b one cycle after eop, required 1", result_valid);
        end
        tests++;
        if (exp_q[exp_q.size() - 1] !== res_t'({4'd5, 17'd500, 6'h3D, 1'b1, 1'b0})) begin
            fails++;
            $display("[TB] FAIL clean_model: model gave %h, required bin5 mag500", exp_q[exp_q.size() - 1]);
        end
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL clean_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL clean_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_tie_mirror_fullscale();
        clear_frame();
        fre[0] = 1000;
        fre[3] = 60;     fim[3] = -40;
        fre[6] = -100;
        fre[12] = 900;
        add_frame(N, -1, 2'b00, 6'($urandom));
        clear_frame();
        fre[2] = 32767;  fim[2] = 32767;
        fre[7] = -32768; fim[7] = -32768;
        fre[8] = 30000;  fim[8] = 30000;
        add_frame(N, -1, 2'b00, 6'($urandom));
        send_stream(1);
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL tie_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL tie_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short_error_abort();
        rand_fill();
        add_frame(9, -1, 2'b00, 6'($urandom));
        rand_fill();
        add_frame(N, 4, 2'b01, 6'($urandom));
        rand_fill();
        add_frame(6, -1, 2'b00, 6'($urandom));
        stim.delete(stim.size() - 1);
        add_beat(fre[5], fim[5], 1'b0, 1'b0, 2'b00, 6'h00, 1'b1);
        rand_fill();
        add_frame(N, -1, 2'b00, 6'($urandom));
        rand_fill();
        add_frame(20, -1, 2'b00, 6'($urandom));
        rand_fill();
        add_frame(1, -1, 2'b00, 6'($urandom));
        send_stream(1);
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL abort_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL abort_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_threshold();
        clear_frame();
        fre[1] = 25;  fim[1] = -25;
        fre[4] = -50;
        fre[10] = 400;
        add_frame(N, -1, 2'b00, 6'($urandom));
        clear_frame();
        fre[3] = 50;
        fre[7] = 26;  fim[7] = 25;
        add_frame(N, -1, 2'b00, 6'($urandom));
        send_stream(1);
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL thresh_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL thresh_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        set_ready(1'b0);
        rand_fill();
        add_frame(N, -1, 2'b00, 6'($urandom));
        send_stream(1);
        #1;
        tests++;
        if (source_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_ready_drop: source_ready=%0b with result pending, required 0", source_ready);
        end
        rand_fill();
        add_frame(N, -1, 2'b00, 6'($urandom));
        fork
            send_stream(1);
            begin
                repeat (10) @(posedge clk);
                #1;
                tests++;
                if (result_valid !== 1'b1 || got_q.size() != 0) begin
                    fails++;
                    $display("[TB] FAIL bp_hold: result_valid=%0b taken=%0d, required 1 and 0", result_valid, got_q.size());
                end
                result_ready = 1'b1;
                @(posedge clk);
                #1 result_ready = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (result_valid !== 1'b1 || got_q.size() != 1) begin
            fails++;
            $display("[TB] FAIL bp_second_pending: result_valid=%0b taken=%0d, required 1 and 1", result_valid, got_q.size());
        end
        result_ready = 1'b1;
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL bp_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        set_ready(1'b0);
        rand_fill();
        add_frame(N, -1, 2'b00, 6'h15);
        send_stream(0);
        rand_fill();
        add_frame(N, -1, 2'b00, 6'($urandom));
        repeat (N - 7) stim.delete(stim.size() - 1);
        fork
            send_stream(0);
            begin
                repeat (4) @(posedge clk);
                #1 result_ready = 1'b1;
            end
        join
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({peak_bin, peak_mag, peak_exp, peak_found, frame_err, result_valid, source_ready} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_midframe_outputs: got bin=%0d mag=%0d exp=%0d rv=%0b rdy=%0b, required all 0",
                     peak_bin, peak_mag, peak_exp, result_valid, source_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        clear_frame();
        fre[7] = -120;  fim[7] = 80;
        fre[2] = 199;
        add_frame(N, -1, 2'b00, 6'h2A);
        send_stream(1);
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL reset_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL reset_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int lens[6] = '{16, 16, 16, 9, 17, 1};
        for (int k = 0; k < 12; k++) begin
            rand_fill();
            if ($urandom_range(0, 3) == 0) add_beat(5, 5, 1'b0, 1'b1, 2'b00, 6'h00, 1'b1);
            add_frame(lens[$urandom_range(0, 5)],
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1,
                      2'($urandom_range(1, 3)), 6'($urandom));
        end
        send_stream(1);
        wait_results();
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL random_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL random_result[%0d]: got %p, required %p", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset_n      = 1'b1;
        result_ready = 1'b1;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        source_error = 2'b00;
        source_real  = '0;
        source_imag  = '0;
        source_exp   = '0;
        test_reset();
        test_clean();
        test_tie_mirror_fullscale();
        test_short_error_abort();
        test_threshold();
        test_back_to_back();
        test_reset_midframe();
        applyStimulus_reset(2);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
